// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//
// Multi-cycle instruction sequencer for the 8-bit accumulator CPU. It fetches
// one instruction per pass from the shared single-port memory, then drives
// the memory strobes and the accumulator/ALU controls through a fixed state
// sequence. Every memory access waits for mem_ready. If an access stalls for
// too long, the block sets a sticky fault and halts. The block owns the
// program counter and the instruction register.
//
// Parameters
//   PC_W     PC / memory address width (>= 4)
//   TIMEOUT  wait-cycle limit before a memory access faults (1..255)
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      leave IDLE and begin fetching at the current pc
//   mem_data   memory read data, valid while mem_ready = 1
//   mem_ready  memory completes the current access this cycle
//   mem_rd     memory read strobe
//   mem_wr     memory write strobe
//   mem_addr   memory address (pc, or the operand in MEM_RD / MEM_WR)
//   instr_en   instruction-register load (fetch completing)
//   acc_en     accumulator load enable (operand read completing)
//   alu_op     ALU operation, meaningful only in MEM_RD
//   pc         program counter
//   ir         current instruction
//   busy       a program is running (neither IDLE nor HALT)
//   halt       HALT state
//   fault      sticky memory-timeout flag
//   illegal    one-cycle pulse when DECODE sees an undefined opcode
// ---------------------------------------------------------------------------
module cpu_sequencer #(
   parameter int PC_W    = 5,
   parameter int TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [7:0]      mem_data,
   input  logic            mem_ready,
   output logic            mem_rd,
   output logic            mem_wr,
   output logic [PC_W-1:0] mem_addr,
   output logic            instr_en,
   output logic            acc_en,
   output logic [3:0]      alu_op,
   output logic [PC_W-1:0] pc,
   output logic [7:0]      ir,
   output logic            busy,
   output logic            halt,
   output logic            fault,
   output logic            illegal
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MEM_RD,
      S_MEM_WR,
      S_HALT
   } state_t;

   localparam logic [3:0] OP_NOP   = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_SUB   = 4'b0010;
   localparam logic [3:0] OP_LOAD  = 4'b0011;
   localparam logic [3:0] OP_STORE = 4'b0100;
   localparam logic [3:0] OP_HALT  = 4'b1111;

   state_t          state;
   state_t          state_nxt;
   logic [7:0]      wait_cnt;
   logic            wait_state;
   logic            timeout_hit;
   logic [3:0]      opcode;
   logic [PC_W-1:0] op_addr;

   assign opcode  = ir[7:4];
   assign op_addr = PC_W'(ir[3:0]);

   // These are the states that wait on mem_ready. A stall reaching TIMEOUT
   // faults only when ready is still low. Ready in that same cycle wins.
   assign wait_state  = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
   assign timeout_hit = wait_state && !mem_ready && (wait_cnt == 8'(TIMEOUT));

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before the edge. The asynchronous reset
   // drops the state to IDLE at once. All decoded outputs then fall without
   // waiting for a clock.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         pc       <= '0;
         ir       <= '0;
         wait_cnt <= '0;
         fault    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (instr_en) begin
            ir <= mem_data;
            pc <= pc + PC_W'(1);
         end
         // The counter advances only while the same access keeps stalling.
         // Any state change clears it, so each new access starts from zero.
         if (wait_state && !mem_ready && (state_nxt == state))
            wait_cnt <= wait_cnt + 8'd1;
         else
            wait_cnt <= '0;
         if (timeout_hit)
            fault <= 1'b1;
      end
   end

   // NOTE: every output and the next state get a default before the case.
   // No path can then leave a value unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = pc;
      instr_en  = 1'b0;
      acc_en    = 1'b0;
      alu_op    = 4'b0000;
      busy      = 1'b1;
      halt      = 1'b0;
      illegal   = 1'b0;

      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start)
               state_nxt = S_FETCH;
         end

         S_FETCH: begin
            mem_rd = 1'b1;
            if (mem_ready) begin
               instr_en  = 1'b1;
               state_nxt = S_DECODE;
            end else if (timeout_hit) begin
               state_nxt = S_HALT;
            end
         end

         S_DECODE: begin
            case (opcode)
               OP_ADD, OP_SUB, OP_LOAD: state_nxt = S_MEM_RD;
               OP_STORE:                state_nxt = S_MEM_WR;
               OP_HALT:                 state_nxt = S_HALT;
               OP_NOP:                  state_nxt = S_FETCH;
               default: begin
                  // Undefined opcodes flag once, then execute as a NOP.
                  illegal   = 1'b1;
                  state_nxt = S_FETCH;
               end
            endcase
         end

         S_MEM_RD: begin
            mem_rd   = 1'b1;
            mem_addr = op_addr;
            // Only ADD/SUB/LOAD reach this state. Their opcodes are the ALU codes.
            alu_op   = opcode;
            if (mem_ready) begin
               acc_en    = 1'b1;
               state_nxt = S_FETCH;
            end else if (timeout_hit) begin
               state_nxt = S_HALT;
            end
         end

         S_MEM_WR: begin
            mem_wr   = 1'b1;
            mem_addr = op_addr;
            if (mem_ready)
               state_nxt = S_FETCH;
            else if (timeout_hit)
               state_nxt = S_HALT;
         end

         S_HALT: begin
            busy = 1'b0;
            halt = 1'b1;
         end

         default: begin
            busy      = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
//
// Self-checking bench for cpu_sequencer (PC_W = 5, TIMEOUT = 15). A small
// array models the memory and serves mem_data combinationally from mem_addr.
// The main program run is table-driven: each row gives the inputs for one
// cycle and the outputs expected in that cycle. Wait states, the illegal
// opcode with PC wrap, the timeout boundary and reset mid-access are covered
// by short hand-written sequences. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

   localparam int PC_W    = 5;
   localparam int TIMEOUT = 15;

   logic            clk = 1'b0;
   logic            reset_n = 1'b1;
   logic            start = 1'b0;
   logic            mem_ready = 1'b0;
   logic [7:0]      mem_data;
   logic            mem_rd;
   logic            mem_wr;
   logic [PC_W-1:0] mem_addr;
   logic            instr_en;
   logic            acc_en;
   logic [3:0]      alu_op;
   logic [PC_W-1:0] pc;
   logic [7:0]      ir;
   logic            busy;
   logic            halt;
   logic            fault;
   logic            illegal;

   logic [7:0] mem [0:31];

   int errors = 0;
   int checks = 0;

   cpu_sequencer #(.PC_W(PC_W), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .mem_data  (mem_data),
      .mem_ready (mem_ready),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .instr_en  (instr_en),
      .acc_en    (acc_en),
      .alu_op    (alu_op),
      .pc        (pc),
      .ir        (ir),
      .busy      (busy),
      .halt      (halt),
      .fault     (fault),
      .illegal   (illegal)
   );

   assign mem_data = mem[mem_addr];

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Move to just after the next rising edge, where inputs are changed.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset, then return at rising edge + 1 with the DUT in IDLE.
   task automatic do_reset();
      start     = 1'b0;
      mem_ready = 1'b0;
      reset_n   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   // Every observable output packed into one word for the table compare.
   function automatic logic [21:0] obs();
      return {mem_rd, mem_wr, instr_en, acc_en, busy, halt, fault, illegal,
              alu_op, mem_addr, pc};
   endfunction

   typedef struct {
      logic       start;
      logic       ready;
      logic       rd;
      logic       wr;
      logic       ie;
      logic       ae;
      logic       busy;
      logic       halt;
      logic [3:0] alu;
      logic [4:0] addr;
      logic [4:0] pc;
   } vec_t;

   function automatic vec_t mk(input int st, input int rdy, input int rd, input int wr,
                               input int ie, input int ae, input int bsy, input int hlt,
                               input int alu, input int addr, input int pcv);
      vec_t v;
      v.start = st[0];
      v.ready = rdy[0];
      v.rd    = rd[0];
      v.wr    = wr[0];
      v.ie    = ie[0];
      v.ae    = ae[0];
      v.busy  = bsy[0];
      v.halt  = hlt[0];
      v.alu   = alu[3:0];
      v.addr  = addr[4:0];
      v.pc    = pcv[4:0];
      return v;
   endfunction

   function automatic logic [21:0] expv(input vec_t v);
      return {v.rd, v.wr, v.ie, v.ae, v.busy, v.halt, 1'b0, 1'b0, v.alu, v.addr, v.pc};
   endfunction

   vec_t vecs [14];

   initial begin
      int         ill_cnt;
      int         ill_cyc;
      logic [4:0] ill_pc;
      logic [7:0] ill_ir;
      int         hold_ok;
      int         ie_seen;
      int         ae_cnt;
      logic       ws_ready [1:9];
      logic       ws_ie    [1:9];
      logic       ws_ae    [1:9];

      // Program run, mem_ready tied high. Columns are start, ready, then the
      // expected mem_rd, mem_wr, instr_en, acc_en, busy, halt, alu_op,
      // mem_addr and pc.
      vecs[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); // IDLE, start sampled
      vecs[1]  = mk(0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0); // FETCH @0 (LOAD 5)
      vecs[2]  = mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1); // DECODE
      vecs[3]  = mk(0, 1, 1, 0, 0, 1, 1, 0, 3, 5, 1); // MEM_RD @5, LOAD
      vecs[4]  = mk(0, 1, 1, 0, 1, 0, 1, 0, 0, 1, 1); // FETCH @1 (ADD 6)
      vecs[5]  = mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 2, 2); // DECODE
      vecs[6]  = mk(0, 1, 1, 0, 0, 1, 1, 0, 1, 6, 2); // MEM_RD @6, ADD
      vecs[7]  = mk(0, 1, 1, 0, 1, 0, 1, 0, 0, 2, 2); // FETCH @2 (STORE 7)
      vecs[8]  = mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 3, 3); // DECODE
      vecs[9]  = mk(0, 1, 0, 1, 0, 0, 1, 0, 0, 7, 3); // MEM_WR @7
      vecs[10] = mk(0, 1, 1, 0, 1, 0, 1, 0, 0, 3, 3); // FETCH @3 (HALT)
      vecs[11] = mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 4, 4); // DECODE
      vecs[12] = mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 4, 4); // HALT, 11 edges after start
      vecs[13] = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 4, 4); // HALT holds, start ignored

      for (int i = 0; i < 32; i++) mem[i] = 8'h00;

      // ---- Reset state ----
      do_reset();
      @(negedge clk);
      check("reset_outputs", 32'({obs(), ir}), 32'd0);
      tick();

      // ---- Program LOAD 5, ADD 6, STORE 7, HALT ----
      mem[0] = 8'h35; mem[1] = 8'h16; mem[2] = 8'h47; mem[3] = 8'hF0;
      mem[5] = 8'h0A; mem[6] = 8'h03; mem[7] = 8'h00;
      for (int r = 0; r < 14; r++) begin
         start     = vecs[r].start;
         mem_ready = vecs[r].ready;
         @(negedge clk);
         check($sformatf("prog_row%0d", r), 32'(obs()), 32'(expv(vecs[r])));
         tick();
      end
      check("prog_ir_halt", 32'(ir), 32'h0000_00F0);

      // ---- Wait states: LOAD 5, three stall cycles per access ----
      // Cycle-by-cycle plan: FETCH x4, DECODE, MEM_RD x4.
      ws_ready = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      ws_ie    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      ws_ae    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      mem[0] = 8'h35;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      ae_cnt = 0;
      for (int c = 1; c <= 9; c++) begin
         mem_ready = ws_ready[c];
         @(negedge clk);
         if (acc_en) ae_cnt++;
         check($sformatf("wait_cyc%0d_ie_ae", c), 32'({instr_en, acc_en}), 32'({ws_ie[c], ws_ae[c]}));
         tick();
      end
      mem_ready = 1'b1;
      @(negedge clk);
      check("wait_acc_en_count", 32'(ae_cnt), 32'd1);
      check("wait_next_fetch", 32'({mem_rd, mem_addr, pc}), 32'({1'b1, 5'd1, 5'd1}));
      tick();

      // ---- Illegal opcode at address 31 and PC wrap ----
      do_reset();
      for (int i = 0; i < 31; i++) mem[i] = 8'h00;
      mem[31]   = 8'h80;
      mem_ready = 1'b1;
      start     = 1'b1;
      tick();
      start   = 1'b0;
      ill_cnt = 0;
      ill_cyc = -1;
      ill_pc  = '1;
      ill_ir  = '0;
      for (int c = 1; c <= 66; c++) begin
         @(negedge clk);
         if (illegal) begin
            ill_cnt++;
            ill_cyc = c;
            ill_pc  = pc;
            ill_ir  = ir;
         end
         if (c == 65)
            check("wrap_fetch_addr0", 32'({mem_rd, mem_addr}), 32'({1'b1, 5'd0}));
         if (c == 66)
            check("wrap_continues", 32'({busy, pc}), 32'({1'b1, 5'd1}));
         tick();
      end
      check("illegal_pulse_count", 32'(ill_cnt), 32'd1);
      check("illegal_cycle", 32'(ill_cyc), 32'd64);
      check("illegal_pc_wrapped", 32'(ill_pc), 32'd0);
      check("illegal_ir", 32'(ill_ir), 32'h80);

      // ---- Timeout: mem_ready stuck low in FETCH ----
      do_reset();
      mem[0]    = 8'h00;
      mem_ready = 1'b0;
      start     = 1'b1;
      tick();
      start   = 1'b0;
      hold_ok = 0;
      ie_seen = 0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (mem_rd && !fault && !halt) hold_ok++;
         if (instr_en) ie_seen++;
         tick();
      end
      @(negedge clk);
      check("timeout_fetch_held", 32'(hold_ok), 32'd16);
      check("timeout_no_instr_en", 32'(ie_seen), 32'd0);
      check("timeout_fault_halt", 32'({fault, halt, busy, mem_rd, pc}),
            32'({1'b1, 1'b1, 1'b0, 1'b0, 5'd0}));
      // Asynchronous reset clears the sticky fault with no clock edge.
      #2;
      reset_n = 1'b0;
      #1;
      check("reset_clears_fault", 32'({fault, halt}), 32'd0);

      // ---- Timeout boundary: ready in the cycle the count reaches TIMEOUT ----
      do_reset();
      mem_ready = 1'b0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 15; c++) tick();
      mem_ready = 1'b1;
      @(negedge clk);
      check("boundary_instr_en", 32'({instr_en, fault}), 32'({1'b1, 1'b0}));
      tick();
      @(negedge clk);
      check("boundary_completes", 32'({fault, halt, busy, pc}),
            32'({1'b0, 1'b0, 1'b1, 5'd1}));
      tick();

      // ---- Reset in the middle of a STORE write ----
      do_reset();
      mem[0]    = 8'h47;
      mem_ready = 1'b1;
      start     = 1'b1;
      tick();                 // FETCH
      start = 1'b0;
      tick();                 // DECODE
      mem_ready = 1'b0;
      tick();                 // MEM_WR, stalled
      @(negedge clk);
      check("midop_in_mem_wr", 32'({mem_wr, mem_addr}), 32'({1'b1, 5'd7}));
      #2;
      reset_n = 1'b0;
      #1;
      check("midop_async_drop", 32'({mem_wr, mem_rd, busy, mem_addr, pc}), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("midop_idle", 32'({busy, halt, fault, mem_wr, pc}), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
